// File: rtl/synth_audio_pkg.sv
// Shared audio-path definitions used by the I2S receiver and driver.
package synth_audio_pkg;

    // Default sample width; matches the 24-bit audio build.
    localparam int AW_DEFAULT = 24;

    // Word-select encoding on the I2S LRCK line.
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Receiver deserialiser states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// Synchroniser for the codec pins plus BCLK rising-edge detect.
// BCLK and the data pins go through the same number of flops so that the
// values presented alongside bclk_rise were sampled at the same instant as
// the BCLK high level that produced the rise.
module i2s_pin_sync #(
    parameter int STAGES = 2,
    parameter int W      = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bclk,
    input  logic [W-1:0] pins,
    output logic [W-1:0] pins_sync,
    output logic         bclk_rise
);

    logic [STAGES-1:0][W:0] stage;
    logic                   bclk_sync;

    // Metastability chain for {pins, bclk}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], {pins, bclk}};
        end
    end

    // Extra register: delayed BCLK for edge detect, data kept aligned to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= 1'b0;
            pins_sync <= '0;
            bclk_rise <= 1'b0;
        end else begin
            bclk_sync <= stage[STAGES-1][0];
            pins_sync <= stage[STAGES-1][W:1];
            bclk_rise <= stage[STAGES-1][0] & ~bclk_sync;
        end
    end

endmodule

// File: rtl/audio_i2s_receiver.sv
// I2S receive deserialiser: codec ADC stream -> aligned left/right words.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | unaligned; waiting for a boundary into the left channel
//   SHIFT | collecting bits of the current channel word (MSB first)
//   DRAIN | word complete; ignoring remaining slot bits until boundary
module audio_i2s_receiver
    import synth_audio_pkg::*;
#(
    parameter int AW          = AW_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic          OSC_CLK,
    input  logic          reset_reg_N,
    input  logic          iAUD_BCLK,
    input  logic          iAUD_ADCLRCK,
    input  logic          iAUD_ADCDAT,
    output logic [AW-1:0] o_lsound_in,
    output logic [AW-1:0] o_rsound_in,
    output logic          o_sample_valid,
    output logic          o_frame_err
);

    localparam int             CW       = $clog2(AW + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(AW - 1);

    logic [1:0]    pins_sync;
    logic          bclk_rise;
    logic          lrck;
    logic          dat;
    logic          lr_prev;
    logic          boundary;
    logic [AW-1:0] word_next;

    rx_state_t     state;
    logic          ch;
    logic [CW-1:0] cnt;
    logic [AW-1:0] shreg;
    logic [AW-1:0] l_hold;
    logic          l_pend;

    i2s_pin_sync #(
        .STAGES (SYNC_STAGES),
        .W      (2)
    ) u_pin_sync (
        .clk       (OSC_CLK),
        .rst_n     (reset_reg_N),
        .bclk      (iAUD_BCLK),
        .pins      ({iAUD_ADCDAT, iAUD_ADCLRCK}),
        .pins_sync (pins_sync),
        .bclk_rise (bclk_rise)
    );

    assign lrck      = pins_sync[0];
    assign dat       = pins_sync[1];
    // The bit on a boundary rise is the previous channel's LSB slot.
    assign boundary  = bclk_rise && (lrck != lr_prev);
    assign word_next = {shreg[AW-2:0], dat};

    // Channel tracking, bit counter and state transitions, advanced on bclk_rise only.
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state       <= IDLE;
            ch          <= LEFT;
            cnt         <= '0;
            lr_prev     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            if (bclk_rise) begin
                lr_prev <= lrck;
                case (state)
                    IDLE: begin
                        // Only a left start aligns us, so pairs are always L then R.
                        if (boundary && (lrck == LEFT)) begin
                            state <= SHIFT;
                            ch    <= LEFT;
                            cnt   <= '0;
                        end
                    end
                    SHIFT: begin
                        if (cnt == CNT_LAST) begin
                            // Exact-width slots: the LSB arrives on the next boundary.
                            if (boundary) begin
                                state <= SHIFT;
                                ch    <= lrck;
                                cnt   <= '0;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (boundary) begin
                            o_frame_err <= 1'b1;
                            ch          <= lrck;
                            cnt         <= '0;
                            state       <= (lrck == LEFT) ? SHIFT : IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (boundary) begin
                            state <= SHIFT;
                            ch    <= lrck;
                            cnt   <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Shift register, left hold, and paired output commit.
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            shreg          <= '0;
            l_hold         <= '0;
            l_pend         <= 1'b0;
            o_lsound_in    <= '0;
            o_rsound_in    <= '0;
            o_sample_valid <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            if (bclk_rise && (state == SHIFT)) begin
                shreg <= word_next;
                if (cnt == CNT_LAST) begin
                    if (ch == LEFT) begin
                        l_hold <= word_next;
                        l_pend <= 1'b1;
                    end else if (l_pend) begin
                        o_lsound_in    <= l_hold;
                        o_rsound_in    <= word_next;
                        o_sample_valid <= 1'b1;
                        l_pend         <= 1'b0;
                    end
                end else if (boundary) begin
                    // A short word invalidates any pending left half.
                    l_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Directed bench for audio_i2s_receiver (AW=24) with a pair scoreboard for the random run.
module tb_audio_i2s_receiver;

    localparam int AW = 24;

    logic          OSC_CLK = 1'b0;
    logic          reset_reg_N = 1'b0;
    logic          bclk = 1'b0;
    logic          lrck = 1'b1;
    logic          dat  = 1'b0;
    logic [AW-1:0] l_out;
    logic [AW-1:0] r_out;
    logic          valid;
    logic          ferr;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int err_run = 0;
    int err_run_max = 0;
    int half = 40;
    logic carry = 1'b0;
    logic sb_on = 1'b0;
    logic [23:0] sb_l[$];
    logic [23:0] sb_r[$];

    always #5 OSC_CLK = ~OSC_CLK;

    audio_i2s_receiver #(
        .AW          (AW),
        .SYNC_STAGES (2)
    ) dut (
        .OSC_CLK        (OSC_CLK),
        .reset_reg_N    (reset_reg_N),
        .iAUD_BCLK      (bclk),
        .iAUD_ADCLRCK   (lrck),
        .iAUD_ADCDAT    (dat),
        .o_lsound_in    (l_out),
        .o_rsound_in    (r_out),
        .o_sample_valid (valid),
        .o_frame_err    (ferr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor and scoreboard, sampled on the falling edge.
    always @(negedge OSC_CLK) begin
        logic [23:0] el;
        logic [23:0] er;
        if (ferr) begin
            if (err_run == 0) err_cnt++;
            err_run++;
            if (err_run > err_run_max) err_run_max = err_run;
        end else begin
            err_run = 0;
        end
        if (valid) begin
            valid_cnt++;
            if (sb_on) begin
                check_eq("sb_pair_expected", (sb_l.size() != 0), 1);
                if (sb_l.size() != 0) begin
                    el = sb_l.pop_front();
                    er = sb_r.pop_front();
                    check_eq("sb_left", l_out, el);
                    check_eq("sb_right", r_out, er);
                end
            end
        end
    end

    task automatic send_bit(input logic lr, input logic d);
        lrck = lr;
        dat  = d;
        #(half);
        bclk = 1'b1;
        #(half);
        bclk = 1'b0;
    endtask

    // Slot bits are MSB-first in bits[sw-1:0]; data lags LRCK by one BCLK.
    task automatic send_slot(input logic lr, input logic [31:0] bits, input int sw);
        for (int j = 0; j < sw; j++) begin
            send_bit(lr, carry);
            carry = bits[sw-1-j];
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int sw);
        send_slot(1'b0, (sw == 32) ? {l, 8'hFF} : {8'h00, l}, sw);
        send_slot(1'b1, (sw == 32) ? {r, 8'hFF} : {8'h00, r}, sw);
    endtask

    // One left-slot bit: the boundary that completes the preceding right word.
    task automatic close_frame();
        send_bit(1'b0, carry);
        repeat (12) @(negedge OSC_CLK);
    endtask

    task automatic do_reset();
        reset_reg_N = 1'b0;
        bclk  = 1'b0;
        lrck  = 1'b1;
        dat   = 1'b0;
        carry = 1'b0;
        repeat (3) @(posedge OSC_CLK);
        #2;
        check_eq("rst_left", l_out, 0);
        check_eq("rst_right", r_out, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_err", ferr, 0);
        reset_reg_N = 1'b1;
        repeat (2) @(posedge OSC_CLK);
        #2;
    endtask

    initial begin
        int v0;
        int e0;
        logic [31:0] bits;
        logic [23:0] rl;
        logic [23:0] rr;

        #2;
        // 1: plain 24-bit frame
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_slot(1'b1, 32'h0, 24);
        send_frame(24'h800001, 24'h7FFFFE, 24);
        close_frame();
        check_eq("t1_valid_count", valid_cnt - v0, 1);
        check_eq("t1_err_count", err_cnt - e0, 0);
        check_eq("t1_left", l_out, 32'h800001);
        check_eq("t1_right", r_out, 32'h7FFFFE);

        // 2: 32-bit slots carrying 24-bit data
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_slot(1'b1, 32'h0, 32);
        send_frame(24'hABCDEF, 24'h123456, 32);
        close_frame();
        check_eq("t2_valid_count", valid_cnt - v0, 1);
        check_eq("t2_err_count", err_cnt - e0, 0);
        check_eq("t2_left", l_out, 32'hABCDEF);
        check_eq("t2_right", r_out, 32'h123456);

        // 3: stream joins mid right channel
        do_reset();
        v0 = valid_cnt;
        send_slot(1'b1, 32'h000002D7, 10);
        check_eq("t3_no_early_valid", valid_cnt - v0, 0);
        send_frame(24'h135790, 24'hFEDCBA, 24);
        close_frame();
        check_eq("t3_valid_count", valid_cnt - v0, 1);
        check_eq("t3_left", l_out, 32'h135790);
        check_eq("t3_right", r_out, 32'hFEDCBA);

        // 4: left channel cut short after 10 bits
        do_reset();
        v0 = valid_cnt; e0 = err_cnt; err_run_max = 0;
        send_slot(1'b1, 32'h0, 24);
        send_slot(1'b0, 32'h000002AB, 10);
        send_slot(1'b1, 32'h00555555, 24);
        check_eq("t4_err_count", err_cnt - e0, 1);
        check_eq("t4_err_width", err_run_max, 1);
        check_eq("t4_no_valid", valid_cnt - v0, 0);
        send_frame(24'h0F0F0F, 24'hF0F0F0, 24);
        close_frame();
        check_eq("t4_valid_after", valid_cnt - v0, 1);
        check_eq("t4_left", l_out, 32'h0F0F0F);
        check_eq("t4_right", r_out, 32'hF0F0F0);

        // 5: reset during the 12th left bit
        do_reset();
        send_slot(1'b1, 32'h0, 24);
        send_frame(24'h5A5A5A, 24'hA5A5A5, 24);
        bits = 32'h00C3C3C3;
        for (int j = 0; j < 11; j++) begin
            send_bit(1'b0, carry);
            carry = bits[23-j];
        end
        check_eq("t5_pre_left", l_out, 32'h5A5A5A);
        check_eq("t5_pre_right", r_out, 32'hA5A5A5);
        lrck = 1'b0;
        dat  = carry;
        #(half);
        reset_reg_N = 1'b0;
        repeat (3) @(posedge OSC_CLK);
        #2;
        check_eq("t5_rst_left", l_out, 0);
        check_eq("t5_rst_right", r_out, 0);
        check_eq("t5_rst_valid", valid, 0);
        check_eq("t5_rst_err", ferr, 0);
        reset_reg_N = 1'b1;
        bclk = 1'b1;
        #(half);
        bclk = 1'b0;
        carry = bits[12];
        v0 = valid_cnt;
        for (int j = 12; j < 24; j++) begin
            send_bit(1'b0, carry);
            carry = bits[23-j];
        end
        send_slot(1'b1, 32'h00777777, 24);
        check_eq("t5_hold_zero", l_out, 0);
        send_frame(24'h2468AC, 24'h13579B, 24);
        close_frame();
        check_eq("t5_valid_count", valid_cnt - v0, 1);
        check_eq("t5_left", l_out, 32'h2468AC);
        check_eq("t5_right", r_out, 32'h13579B);

        // 6: 100 random frames with BCLK rate and phase sweep
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_slot(1'b1, 32'h0, 24);
        sb_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rl = 24'($urandom());
            rr = 24'($urandom());
            sb_l.push_back(rl);
            sb_r.push_back(rr);
            half = 25 + (i % 5) * 4;
            #(i % 10);
            send_frame(rl, rr, 24);
        end
        half = 40;
        close_frame();
        sb_on = 1'b0;
        check_eq("t6_valid_count", valid_cnt - v0, 100);
        check_eq("t6_err_count", err_cnt - e0, 0);
        check_eq("t6_sb_drained", sb_l.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
